// File: rtl/max7219_pkg.sv
`default_nettype none
// ============================================================================
// Package : max7219_pkg
// Brief   : MAX7219 register map, sequencer state types, segment patterns.
// Rev     : 1.0  initial release
// ============================================================================
package max7219_pkg;

    localparam logic [7:0] REG_DIGIT0 = 8'h01;
    localparam logic [7:0] REG_DIGIT1 = 8'h02;
    localparam logic [7:0] REG_DIGIT2 = 8'h03;
    localparam logic [7:0] REG_DIGIT3 = 8'h04;
    localparam logic [7:0] REG_DIGIT4 = 8'h05;
    localparam logic [7:0] REG_DIGIT5 = 8'h06;
    localparam logic [7:0] REG_DIGIT6 = 8'h07;
    localparam logic [7:0] REG_DIGIT7 = 8'h08;
    localparam logic [7:0] REG_DECODE = 8'h09;
    localparam logic [7:0] REG_INTENS = 8'h0A;
    localparam logic [7:0] REG_SCAN   = 8'h0B;
    localparam logic [7:0] REG_SHUTDN = 8'h0C;
    localparam logic [7:0] REG_TEST   = 8'h0F;

    // Segment byte layout: bit7 DP, bits6..0 = A..G
    localparam logic [7:0] SEG_0     = 8'h7E;
    localparam logic [7:0] SEG_1     = 8'h30;
    localparam logic [7:0] SEG_2     = 8'h6D;
    localparam logic [7:0] SEG_3     = 8'h79;
    localparam logic [7:0] SEG_4     = 8'h33;
    localparam logic [7:0] SEG_5     = 8'h5B;
    localparam logic [7:0] SEG_6     = 8'h5F;
    localparam logic [7:0] SEG_7     = 8'h70;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h7B;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_B     = 8'h1F;
    localparam logic [7:0] SEG_C     = 8'h4E;
    localparam logic [7:0] SEG_D     = 8'h3D;
    localparam logic [7:0] SEG_E     = 8'h4F;
    localparam logic [7:0] SEG_F     = 8'h47;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DP    = 8'h80;

    localparam logic [2:0] INIT_LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        ST_PWRUP  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_INTENS = 3'd3,
        ST_DIGITS = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_ISSUE   = 2'd0,
        PH_WAIT_HI = 2'd1,
        PH_WAIT_LO = 2'd2
    } cmd_phase_t;

    // {addr, data} of the idx-th power-up command
    function automatic logic [15:0] init_cmd(input logic [2:0] idx, input logic [3:0] intensity);
        case (idx)
            3'd0:    return {REG_SHUTDN, 8'h01};
            3'd1:    return {REG_TEST,   8'h00};
            3'd2:    return {REG_DECODE, 8'h00};
            3'd3:    return {REG_SCAN,   8'h07};
            default: return {REG_INTENS, 4'h0, intensity};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/max7219_display_sched_if.sv
`default_nettype none
// ============================================================================
// Interface : max7219_display_sched_if
// Brief     : Command bus between the display sequencer and the SPI serializer.
// Rev       : 1.0  initial release
// ============================================================================
interface max7219_display_sched_if;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_start;
    logic       cmd_busy;

    modport master (output cmd_addr, output cmd_data, output cmd_start, input  cmd_busy);
    modport slave  (input  cmd_addr, input  cmd_data, input  cmd_start, output cmd_busy);
endinterface
`default_nettype wire

// File: rtl/max7219_hex7seg.sv
`default_nettype none
// ============================================================================
// Module : max7219_hex7seg
// Brief  : Hex nibble to MAX7219 no-decode segment byte (DP bit left clear).
// Rev    : 1.0  initial release
// ============================================================================
module max7219_hex7seg
    import max7219_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/max7219_display_sched.sv
`default_nettype none
// ============================================================================
// Module : max7219_display_sched
// Brief  : MAX7219 command sequencer: power-up wait, init set, digit refresh,
//          intensity tracking. Optional periodic re-init: MAX7219_REINIT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module max7219_display_sched
    import max7219_pkg::*;
#(
    parameter int unsigned PWRUP_CYCLES  = 12000,
    parameter int unsigned ACK_TIMEOUT   = 255
`ifdef MAX7219_REINIT_EN
    ,
    parameter int unsigned REINIT_CYCLES = 12000000
`endif
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits_i,
    input  logic [7:0]  dp_mask_i,
    input  logic [7:0]  blank_mask_i,
    input  logic [3:0]  intensity_i,
    input  logic        update_i,
    output logic        ready_o,
    output logic        init_done_o,
    output logic        ack_err_o,
    max7219_display_sched_if.master cmd
);

    localparam int PWR_W = (PWRUP_CYCLES > 0) ? $clog2(PWRUP_CYCLES + 1) : 1;
    localparam int TO_W  = (ACK_TIMEOUT  > 0) ? $clog2(ACK_TIMEOUT + 1)  : 1;

    seq_state_t       state_q,       state_d;
    cmd_phase_t       phase_q,       phase_d;
    logic [2:0]       idx_q,         idx_d;
    logic [PWR_W-1:0] pwr_cnt_q,     pwr_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,      to_cnt_d;
    logic [31:0]      digits_q,      digits_d;
    logic [7:0]       dp_q,          dp_d;
    logic [7:0]       blank_q,       blank_d;
    logic [3:0]       intens_sent_q, intens_sent_d;
    logic             pend_q,        pend_d;
    logic             digits_req_q,  digits_req_d;
    logic             init_done_q,   init_done_d;
    logic             ack_err_q,     ack_err_d;
    logic [7:0]       addr_q,        addr_d;
    logic [7:0]       data_q,        data_d;
    logic             start_q,       start_d;

    logic             w_cmd_done;
    logic             w_reinit;
    logic [7:0]       w_cmd_addr;
    logic [7:0]       w_cmd_data;
    logic [3:0]       w_nibble;
    logic [7:0]       w_seg;
    logic [7:0]       w_digit_data;

`ifdef MAX7219_REINIT_EN
    localparam int RI_W = (REINIT_CYCLES > 1) ? $clog2(REINIT_CYCLES) : 1;

    logic [RI_W-1:0] ri_cnt_q;
    logic            ri_pend_q;

    // Request is set on counter wrap and consumed when IDLE launches the re-init
    always_ff @(posedge clk) begin
        if (rst) begin
            ri_cnt_q  <= '0;
            ri_pend_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                ri_pend_q <= 1'b0;
            end
            if (ri_cnt_q == RI_W'(REINIT_CYCLES - 1)) begin
                ri_cnt_q  <= '0;
                ri_pend_q <= 1'b1;
            end else begin
                ri_cnt_q  <= ri_cnt_q + 1'b1;
            end
        end
    end

    assign w_reinit = ri_pend_q;
`else
    assign w_reinit = 1'b0;
`endif

    assign w_nibble = digits_q[{idx_q, 2'b00} +: 4];

    max7219_hex7seg u_hex7seg (
        .nibble_i (w_nibble),
        .seg_o    (w_seg)
    );

    assign w_digit_data = (blank_q[idx_q] ? SEG_BLANK : w_seg) | (dp_q[idx_q] ? SEG_DP : 8'h00);

    always_comb begin
        w_cmd_addr = REG_DIGIT0 + {5'd0, idx_q};
        w_cmd_data = w_digit_data;
        case (state_q)
            ST_INIT:   {w_cmd_addr, w_cmd_data} = init_cmd(idx_q, intensity_i);
            ST_INTENS: {w_cmd_addr, w_cmd_data} = {REG_INTENS, 4'h0, intensity_i};
            default:   ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        idx_d         = idx_q;
        pwr_cnt_d     = pwr_cnt_q;
        to_cnt_d      = to_cnt_q;
        digits_d      = digits_q;
        dp_d          = dp_q;
        blank_d       = blank_q;
        intens_sent_d = intens_sent_q;
        pend_d        = pend_q;
        digits_req_d  = digits_req_q;
        init_done_d   = init_done_q;
        ack_err_d     = ack_err_q;
        addr_d        = addr_q;
        data_d        = data_q;
        start_d       = 1'b0;
        w_cmd_done    = 1'b0;

        if (update_i && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end

        if (state_q inside {ST_INIT, ST_INTENS, ST_DIGITS}) begin
            case (phase_q)
                PH_ISSUE: begin
                    if (!cmd.cmd_busy) begin
                        start_d  = 1'b1;
                        addr_d   = w_cmd_addr;
                        data_d   = w_cmd_data;
                        to_cnt_d = '0;
                        phase_d  = PH_WAIT_HI;
                        if (w_cmd_addr == REG_INTENS) begin
                            intens_sent_d = w_cmd_data[3:0];
                        end
                    end
                end
                PH_WAIT_HI: begin
                    if (cmd.cmd_busy) begin
                        phase_d = PH_WAIT_LO;
                    end else if (to_cnt_q >= TO_W'(ACK_TIMEOUT)) begin
                        // Serializer never acknowledged: flag it and move on
                        ack_err_d  = 1'b1;
                        w_cmd_done = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                PH_WAIT_LO: begin
                    if (!cmd.cmd_busy) begin
                        w_cmd_done = 1'b1;
                    end
                end
                default: phase_d = PH_ISSUE;
            endcase
            if (w_cmd_done) begin
                phase_d = PH_ISSUE;
            end
        end

        case (state_q)
            ST_PWRUP: begin
                if (pwr_cnt_q == PWR_W'(PWRUP_CYCLES)) begin
                    state_d = ST_INIT;
                    idx_d   = '0;
                    phase_d = PH_ISSUE;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            ST_INIT: begin
                if (w_cmd_done) begin
                    if (idx_q == INIT_LAST_IDX) begin
                        state_d  = ST_DIGITS;
                        idx_d    = '0;
                        digits_d = digits_i;
                        dp_d     = dp_mask_i;
                        blank_d  = blank_mask_i;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DIGITS: begin
                if (w_cmd_done) begin
                    if (idx_q == 3'd7) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_INTENS: begin
                if (w_cmd_done) begin
                    idx_d = '0;
                    if (digits_req_q) begin
                        state_d      = ST_DIGITS;
                        digits_req_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                idx_d   = '0;
                phase_d = PH_ISSUE;
                if (w_reinit) begin
                    state_d = ST_INIT;
                    if (update_i) begin
                        pend_d = 1'b1;
                    end
                end else if (pend_q || update_i) begin
                    digits_d = digits_i;
                    dp_d     = dp_mask_i;
                    blank_d  = blank_mask_i;
                    pend_d   = 1'b0;
                    if (intensity_i != intens_sent_q) begin
                        state_d      = ST_INTENS;
                        digits_req_d = 1'b1;
                    end else begin
                        state_d = ST_DIGITS;
                    end
                end else if (intensity_i != intens_sent_q) begin
                    state_d      = ST_INTENS;
                    digits_req_d = 1'b0;
                end
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_PWRUP;
            phase_q       <= PH_ISSUE;
            idx_q         <= '0;
            pwr_cnt_q     <= '0;
            to_cnt_q      <= '0;
            digits_q      <= '0;
            dp_q          <= '0;
            blank_q       <= '0;
            intens_sent_q <= '0;
            pend_q        <= 1'b0;
            digits_req_q  <= 1'b0;
            init_done_q   <= 1'b0;
            ack_err_q     <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            idx_q         <= idx_d;
            pwr_cnt_q     <= pwr_cnt_d;
            to_cnt_q      <= to_cnt_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            blank_q       <= blank_d;
            intens_sent_q <= intens_sent_d;
            pend_q        <= pend_d;
            digits_req_q  <= digits_req_d;
            init_done_q   <= init_done_d;
            ack_err_q     <= ack_err_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            start_q       <= start_d;
        end
    end

    assign ready_o       = (state_q == ST_IDLE);
    assign init_done_o   = init_done_q;
    assign ack_err_o     = ack_err_q;
    assign cmd.cmd_addr  = addr_q;
    assign cmd.cmd_data  = data_q;
    assign cmd.cmd_start = start_q;

endmodule
`default_nettype wire

// File: tb/tb_max7219_display_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_max7219_display_sched
// Brief  : Directed self-checking bench with a start/busy serializer model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_max7219_display_sched;

    localparam int unsigned PWRUP  = 16;
    localparam int unsigned ACK_TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digits = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  blank_mask = '0;
    logic [3:0]  intensity = '0;
    logic        update = 1'b0;
    logic        ready;
    logic        init_done;
    logic        ack_err;

    int checks = 0;
    int errors = 0;

    max7219_display_sched_if cmd_if ();

    max7219_display_sched #(
        .PWRUP_CYCLES (PWRUP),
        .ACK_TIMEOUT  (ACK_TO)
`ifdef MAX7219_REINIT_EN
        ,
        .REINIT_CYCLES(2000)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .digits_i     (digits),
        .dp_mask_i    (dp_mask),
        .blank_mask_i (blank_mask),
        .intensity_i  (intensity),
        .update_i     (update),
        .ready_o      (ready),
        .init_done_o  (init_done),
        .ack_err_o    (ack_err),
        .cmd          (cmd_if)
    );

    always #5 clk = ~clk;

    // Serializer model: busy from the cycle after start, 34 cycles long
    logic       model_en = 1'b1;
    logic [5:0] ser_cnt;
    always @(posedge clk) begin
        if (rst)                                   ser_cnt <= '0;
        else if (ser_cnt != 0)                     ser_cnt <= ser_cnt - 1'b1;
        else if (cmd_if.cmd_start && model_en)     ser_cnt <= 6'd34;
    end
    assign cmd_if.cmd_busy = (ser_cnt != 0);

    int          cyc = 0;
    logic [15:0] frames[$];
    int          start_cyc[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cmd_if.cmd_start) begin
            frames.push_back({cmd_if.cmd_addr, cmd_if.cmd_data});
            start_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit timed_out);
        timed_out = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (frames.size() >= n && ready) return;
            tick();
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        int first;
        rst = 1'b1;
        digits = 32'h12A45678; dp_mask = 8'h10; blank_mask = 8'h00; intensity = 4'h3; update = 1'b0;
        repeat (4) tick();
        checks++;
        if ({ready, init_done, ack_err, cmd_if.cmd_start, cmd_if.cmd_addr, cmd_if.cmd_data} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b done=%b err=%b start=%b addr=%h data=%h required all zero",
                     ready, init_done, ack_err, cmd_if.cmd_start, cmd_if.cmd_addr, cmd_if.cmd_data);
        end
        frames.delete(); start_cyc.delete();
        rst = 1'b0;
        first = -1;
        for (int n = 1; n <= 100 && first < 0; n++) begin
            tick();
            if (frames.size() != 0) first = n;
        end
        checks++;
        if (first <= int'(PWRUP)) begin
            errors++;
            $display("FAIL pwrup_wait: first start at cycle %0d required > %0d", first, PWRUP);
        end
    endtask

    task automatic test_init_sequence();
        logic [15:0] exp_f [13];
        logic [15:0] got;
        bit          to;
        exp_f = '{16'h0C01, 16'h0F00, 16'h0900, 16'h0B07, 16'h0A03,
                  16'h017F, 16'h0270, 16'h035F, 16'h045B, 16'h05B3, 16'h0677, 16'h076D, 16'h0830};
        wait_frames(13, 800, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL init_timeout: got %0d frames required 13", frames.size());
        end
        for (int i = 0; i < 13; i++) begin
            got = (i < frames.size()) ? frames[i] : 16'hFFFF;
            checks++;
            if (got !== exp_f[i]) begin
                errors++;
                $display("FAIL init_frame%0d: got %h required %h", i, got, exp_f[i]);
            end
        end
        for (int i = 1; i < start_cyc.size(); i++) begin
            checks++;
            if (start_cyc[i] - start_cyc[i-1] < 36) begin
                errors++;
                $display("FAIL start_gap%0d: got %0d cycles required >= 36", i, start_cyc[i] - start_cyc[i-1]);
            end
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done: got %b required 1", init_done);
        end
    endtask

`ifndef MAX7219_REINIT_EN
    task automatic test_update_blank();
        logic [15:0] exp_f [8];
        logic [15:0] got;
        int          rdy_hi;
        bit          to;
        exp_f = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0547, 16'h0647, 16'h0747, 16'h0847};
        frames.delete(); start_cyc.delete();
        digits = 32'hFFFF0000; blank_mask = 8'h0F; dp_mask = 8'h00;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b required 1", ready);
        end
        pulse_update();
        rdy_hi = 0;
        for (int i = 0; i < 400 && frames.size() < 8; i++) begin
            if (ready) rdy_hi++;
            tick();
        end
        checks++;
        if (rdy_hi != 0) begin
            errors++;
            $display("FAIL ready_during_refresh: got %0d ready cycles required 0", rdy_hi);
        end
        wait_frames(8, 100, to);
        repeat (50) tick();
        checks++;
        if (to || frames.size() != 8) begin
            errors++;
            $display("FAIL blank_count: got %0d frames required 8", frames.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < frames.size()) ? frames[i] : 16'hFFFF;
            checks++;
            if (got !== exp_f[i]) begin
                errors++;
                $display("FAIL blank_frame%0d: got %h required %h", i, got, exp_f[i]);
            end
        end
    endtask

    task automatic test_intensity_with_update();
        logic [15:0] exp_f [9];
        logic [15:0] got;
        bit          to;
        exp_f = '{16'h0A0A, 16'h01C7, 16'h024F, 16'h033D, 16'h044E, 16'h051F, 16'h0677, 16'h077B, 16'h087F};
        frames.delete(); start_cyc.delete();
        digits = 32'h89ABCDEF; dp_mask = 8'h01; blank_mask = 8'h00; intensity = 4'hA;
        pulse_update();
        digits = 32'h0; dp_mask = 8'h00;
        wait_frames(9, 600, to);
        repeat (60) tick();
        checks++;
        if (to || frames.size() != 9) begin
            errors++;
            $display("FAIL intens_count: got %0d frames required 9", frames.size());
        end
        for (int i = 0; i < 9; i++) begin
            got = (i < frames.size()) ? frames[i] : 16'hFFFF;
            checks++;
            if (got !== exp_f[i]) begin
                errors++;
                $display("FAIL intens_frame%0d: got %h required %h", i, got, exp_f[i]);
            end
        end
    endtask

    task automatic test_update_collapse();
        logic [15:0] got;
        logic [15:0] exp_v;
        bit          to;
        frames.delete(); start_cyc.delete();
        digits = 32'h11111111; dp_mask = 8'h00; blank_mask = 8'h00;
        pulse_update();
        for (int i = 0; i < 200 && frames.size() < 2; i++) tick();
        digits = 32'h22222222; pulse_update(); tick();
        digits = 32'h33333333; pulse_update(); tick();
        digits = 32'h44444444; pulse_update(); tick();
        wait_frames(16, 1000, to);
        repeat (60) tick();
        checks++;
        if (to || frames.size() != 16) begin
            errors++;
            $display("FAIL collapse_count: got %0d frames required 16", frames.size());
        end
        for (int i = 0; i < 16; i++) begin
            exp_v = {8'(i % 8 + 1), (i < 8) ? 8'h30 : 8'h33};
            got   = (i < frames.size()) ? frames[i] : 16'hFFFF;
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL collapse_frame%0d: got %h required %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_ack_timeout();
        logic [15:0] got;
        bit          to;
        int          gap;
        frames.delete(); start_cyc.delete();
        model_en = 1'b0;
        digits = 32'h0; blank_mask = 8'hFF; dp_mask = 8'h00;
        pulse_update();
        for (int i = 0; i < 20 && frames.size() < 1; i++) tick();
        checks++;
        if (ack_err !== 1'b0) begin
            errors++;
            $display("FAIL ack_err_early: got %b required 0", ack_err);
        end
        wait_frames(8, 8 * (ACK_TO + 10) + 50, to);
        checks++;
        if (to || ack_err !== 1'b1) begin
            errors++;
            $display("FAIL ack_err_set: got %b frames=%0d required 1 with 8 frames", ack_err, frames.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < frames.size()) ? frames[i] : 16'hFFFF;
            checks++;
            if (got !== {8'(i + 1), 8'h00}) begin
                errors++;
                $display("FAIL timeout_frame%0d: got %h required %h", i, got, {8'(i + 1), 8'h00});
            end
        end
        gap = (start_cyc.size() > 1) ? start_cyc[1] - start_cyc[0] : 0;
        checks++;
        if (gap < int'(ACK_TO) || gap > int'(ACK_TO) + 4) begin
            errors++;
            $display("FAIL timeout_gap: got %0d cycles required %0d..%0d", gap, ACK_TO, ACK_TO + 4);
        end
        model_en = 1'b1;
    endtask

    task automatic test_rst_mid_frame();
        int first;
        frames.delete(); start_cyc.delete();
        digits = 32'h12A45678; dp_mask = 8'h10; blank_mask = 8'h00; intensity = 4'h3;
        pulse_update();
        for (int i = 0; i < 200 && !(frames.size() >= 1 && cmd_if.cmd_busy); i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({cmd_if.cmd_start, ready, init_done, ack_err, cmd_if.cmd_addr} !== 12'h0) begin
            errors++;
            $display("FAIL rst_mid_frame: got start=%b rdy=%b done=%b err=%b addr=%h required all zero",
                     cmd_if.cmd_start, ready, init_done, ack_err, cmd_if.cmd_addr);
        end
        repeat (2) tick();
        frames.delete(); start_cyc.delete();
        rst = 1'b0;
        first = -1;
        for (int n = 1; n <= 100 && first < 0; n++) begin
            tick();
            if (frames.size() != 0) first = n;
        end
        checks++;
        if (first <= int'(PWRUP)) begin
            errors++;
            $display("FAIL pwrup_restart: first start at cycle %0d required > %0d", first, PWRUP);
        end
    endtask
`endif

`ifdef MAX7219_REINIT_EN
    task automatic test_reinit();
        logic [15:0] exp_f [13];
        logic [15:0] got;
        int          done_lo;
        exp_f = '{16'h0C01, 16'h0F00, 16'h0900, 16'h0B07, 16'h0A03,
                  16'h017F, 16'h0270, 16'h035F, 16'h045B, 16'h05B3, 16'h0677, 16'h076D, 16'h0830};
        frames.delete(); start_cyc.delete();
        done_lo = 0;
        for (int i = 0; i < 2800 && !(frames.size() >= 13 && ready); i++) begin
            if (!init_done) done_lo++;
            tick();
        end
        checks++;
        if (done_lo != 0) begin
            errors++;
            $display("FAIL reinit_done_sticky: got %0d low cycles required 0", done_lo);
        end
        for (int i = 0; i < 13; i++) begin
            got = (i < frames.size()) ? frames[i] : 16'hFFFF;
            checks++;
            if (got !== exp_f[i]) begin
                errors++;
                $display("FAIL reinit_frame%0d: got %h required %h", i, got, exp_f[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init_sequence();
`ifdef MAX7219_REINIT_EN
        test_reinit();
`else
        test_update_blank();
        test_intensity_with_update();
        test_update_collapse();
        test_ack_timeout();
        test_rst_mid_frame();
        test_init_sequence();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
